// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between video line bursts, CPU and aux single-word accesses
// Ports: clk/reset (sync, active-high); vid_* burst requester (valid/rdata per word, done with last);
// cpu_*/aux_* single-word requesters (level req, ack pulse with rdata); mem_* controller command port.
module sdram_arbiter #(
  parameter int C_addr_bits = 24,
  parameter int C_data_bits = 16,
  parameter int C_burst_len = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vid_req,
  input  logic [C_addr_bits-1:0] vid_addr,
  output logic                   vid_valid,
  output logic [C_data_bits-1:0] vid_rdata,
  output logic                   vid_done,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [C_addr_bits-1:0] cpu_addr,
  input  logic [C_data_bits-1:0] cpu_wdata,
  output logic                   cpu_ack,
  output logic [C_data_bits-1:0] cpu_rdata,
  input  logic                   aux_req,
  input  logic                   aux_we,
  input  logic [C_addr_bits-1:0] aux_addr,
  input  logic [C_data_bits-1:0] aux_wdata,
  output logic                   aux_ack,
  output logic [C_data_bits-1:0] aux_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [C_addr_bits-1:0] mem_addr,
  output logic [C_data_bits-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [C_data_bits-1:0] mem_rdata
);
  localparam int CW = $clog2(C_burst_len);
  localparam logic [CW-1:0] LAST = CW'(C_burst_len - 1);
  typedef enum logic [1:0] {IDLE, SINGLE, VBURST, GAP} state_t;
  state_t state, state_n;
  logic rr, vid_last, owner_aux;
  logic [CW-1:0] cnt;
  logic any_nv, pick_cpu, grant_vid, grant_nv, burst_end;
  // rr=0 points at CPU; vid_last forces one non-video access between bursts
  always_comb begin
    any_nv = cpu_req | aux_req;
    pick_cpu = cpu_req & (~aux_req | ~rr);
    grant_vid = vid_req & ~(vid_last & any_nv);
    grant_nv = ~grant_vid & any_nv;
    burst_end = mem_req & mem_ack & (cnt == LAST);
    state_n = (state == IDLE)   ? (grant_vid ? VBURST : grant_nv ? SINGLE : IDLE) :
              (state == SINGLE) ? ((mem_req & mem_ack) ? GAP : SINGLE) :
              (state == VBURST) ? (burst_end ? GAP : VBURST) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b0;
      vid_last <= 1'b0;
      owner_aux <= 1'b0;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      vid_valid <= 1'b0;
      vid_done <= 1'b0;
      cpu_rdata <= '0;
      aux_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      state <= state_n;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      vid_valid <= 1'b0;
      vid_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vid) begin
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= vid_addr;
            cnt <= '0;
          end else if (grant_nv) begin
            mem_req <= 1'b1;
            owner_aux <= ~pick_cpu;
            mem_we <= pick_cpu ? cpu_we : aux_we;
            mem_addr <= pick_cpu ? cpu_addr : aux_addr;
            mem_wdata <= pick_cpu ? cpu_wdata : aux_wdata;
            if (cpu_req & aux_req) rr <= ~rr;
          end
        end
        SINGLE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            vid_last <= 1'b0;
            cpu_ack <= ~owner_aux;
            aux_ack <= owner_aux;
            if (~owner_aux & ~mem_we) cpu_rdata <= mem_rdata;
            if (owner_aux & ~mem_we) aux_rdata <= mem_rdata;
          end
        end
        VBURST: begin
          // each word: wait for ack, then one cycle with mem_req low before the next word
          if (~mem_req) mem_req <= 1'b1;
          else if (mem_ack) begin
            mem_req <= 1'b0;
            vid_valid <= 1'b1;
            vid_rdata <= mem_rdata;
            if (cnt == LAST) begin
              vid_done <= 1'b1;
              vid_last <= 1'b1;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
